// File: rtl/gate_bist_ctrl.sv
// BIST sequencer for a 2-input gate: applies all four vectors, checks against TRUTH, reports results.
// Optional continuous mode (stop port, repeating passes) is enabled by defining GATE_BIST_CONTINUOUS_EN.
module gate_bist_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [3:0]  TRUTH         = 4'b0111
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
`ifdef GATE_BIST_CONTINUOUS_EN
  input  logic       stop,
`endif
  input  logic       dut_out,
  output logic       dut_in1,
  output logic       dut_in2,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] num_errors,
  output logic [3:0] fail_vec
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned VEC_W = 2;
  localparam int unsigned ERR_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    CHECK,
    DONE
  } state_t;

  state_t             state, state_nx;
  logic [VEC_W-1:0]   vec, vec_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [VEC_W-1:0]   in_nx;
  logic               busy_nx;
  logic               done_nx;
  logic               pass_nx;
  logic [ERR_W-1:0]   nerr_nx;
  logic [3:0]         fvec_nx;
  logic               stop_req;

`ifdef GATE_BIST_CONTINUOUS_EN
  assign stop_req = stop;
`else
  assign stop_req = 1'b1;
`endif

  // State and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      vec        <= '0;
      cnt        <= '0;
      dut_in1    <= 1'b0;
      dut_in2    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      num_errors <= '0;
      fail_vec   <= '0;
    end else begin
      state      <= state_nx;
      vec        <= vec_nx;
      cnt        <= cnt_nx;
      dut_in1    <= in_nx[1];
      dut_in2    <= in_nx[0];
      busy       <= busy_nx;
      done       <= done_nx;
      pass       <= pass_nx;
      num_errors <= nerr_nx;
      fail_vec   <= fvec_nx;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nx = state;
    vec_nx   = vec;
    cnt_nx   = cnt;
    done_nx  = 1'b0;
    pass_nx  = pass;
    nerr_nx  = num_errors;
    fvec_nx  = fail_vec;

    unique case (state)
      IDLE: begin
        if (start) begin
          nerr_nx  = '0;
          fvec_nx  = '0;
          pass_nx  = 1'b0;
          vec_nx   = '0;
          state_nx = APPLY;
        end
      end
      APPLY: begin
        cnt_nx   = CNT_W'(SETTLE_CYCLES);
        state_nx = (SETTLE_CYCLES != 0) ? SETTLE : CHECK;
      end
      SETTLE: begin
        cnt_nx = (cnt != '0) ? cnt - CNT_W'(1) : '0;
        if (cnt <= CNT_W'(1)) begin
          state_nx = CHECK;
        end
      end
      CHECK: begin
        if (dut_out != TRUTH[vec]) begin
          if (num_errors != '1) begin
            nerr_nx = num_errors + ERR_W'(1);
          end
          fvec_nx[vec] = 1'b1;
        end
        if (vec == VEC_W'(3)) begin
          state_nx = DONE;
        end else begin
          vec_nx   = vec + VEC_W'(1);
          state_nx = APPLY;
        end
      end
      DONE: begin
        done_nx = 1'b1;
        pass_nx = (num_errors == '0);
        // Without continuous mode stop_req is tied high, so DONE always returns to IDLE
        if (stop_req) begin
          state_nx = IDLE;
        end else begin
          vec_nx   = '0;
          state_nx = APPLY;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    busy_nx = (state_nx != IDLE);
    in_nx   = busy_nx ? vec_nx : '0;
  end

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Scoreboard bench for gate_bist_ctrl: DUT a uses SETTLE_CYCLES=1, DUT b uses SETTLE_CYCLES=0.
module tb_gate_bist_ctrl;

  typedef struct {
    logic [3:0]  nerr;
    logic [3:0]  fvec;
    logic        ps;
    int unsigned cyc;
  } exp_t;

  localparam int unsigned LAT_A = 13;
  localparam int unsigned LAT_B = 9;

  logic clock   = 1'b0;
  logic reset   = 1'b1;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic stop_a  = 1'b1;

  logic       out_a, in1_a, in2_a, busy_a, done_a, pass_a;
  logic [3:0] nerr_a, fvec_a;
  logic       out_b, in1_b, in2_b, busy_b, done_b, pass_b;
  logic [3:0] nerr_b, fvec_b;

  int mode_a = 0;  // 0 NAND, 1 stuck-at-1, 2 stuck-at-0, 3 AND
  int mode_b = 0;

  int unsigned cyc = 0;
  int checks = 0;
  int errors = 0;

  exp_t q_a[$];
  exp_t q_b[$];
  logic [1:0] prev_a = 2'b00;
  logic [1:0] prev_b = 2'b00;
  logic [1:0] nxt_a, nxt_b;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic model(input int mode, input logic a, input logic b);
    case (mode)
      0:       return ~(a & b);
      1:       return 1'b1;
      2:       return 1'b0;
      default: return a & b;
    endcase
  endfunction

  assign out_a = model(mode_a, in1_a, in2_a);
  assign out_b = model(mode_b, in1_b, in2_b);

  gate_bist_ctrl #(.SETTLE_CYCLES(1), .TRUTH(4'b0111)) u_dut_a (
    .clock(clock), .reset(reset), .start(start_a),
`ifdef GATE_BIST_CONTINUOUS_EN
    .stop(stop_a),
`endif
    .dut_out(out_a), .dut_in1(in1_a), .dut_in2(in2_a),
    .busy(busy_a), .done(done_a), .pass(pass_a),
    .num_errors(nerr_a), .fail_vec(fvec_a)
  );

  gate_bist_ctrl #(.SETTLE_CYCLES(0), .TRUTH(4'b0111)) u_dut_b (
    .clock(clock), .reset(reset), .start(start_b),
`ifdef GATE_BIST_CONTINUOUS_EN
    .stop(1'b1),
`endif
    .dut_out(out_b), .dut_in1(in1_b), .dut_in2(in2_b),
    .busy(busy_b), .done(done_b), .pass(pass_b),
    .num_errors(nerr_b), .fail_vec(fvec_b)
  );

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic cmp_done(input string tag, input exp_t e, input logic [3:0] ne,
                          input logic [3:0] fv, input logic ps);
    chk({tag, " done cycle"}, int'(cyc), int'(e.cyc));
    chk({tag, " num_errors"}, int'(ne), int'(e.nerr));
    chk({tag, " fail_vec"}, int'(fv), int'(e.fvec));
    chk({tag, " pass"}, int'(ps), int'(e.ps));
  endtask

  // Monitor: pops expectations on each done pulse, flags late/unexpected dones and vector order
  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      if (done_a) begin
        if (q_a.size() == 0) chk("a unexpected done", int'(done_a), 0);
        else begin e = q_a.pop_front(); cmp_done("a", e, nerr_a, fvec_a, pass_a); end
      end else if (q_a.size() != 0 && cyc > q_a[0].cyc) begin
        chk("a late done", int'(done_a), 1);
        void'(q_a.pop_front());
      end
      if (done_b) begin
        if (q_b.size() == 0) chk("b unexpected done", int'(done_b), 0);
        else begin e = q_b.pop_front(); cmp_done("b", e, nerr_b, fvec_b, pass_b); end
      end else if (q_b.size() != 0 && cyc > q_b[0].cyc) begin
        chk("b late done", int'(done_b), 1);
        void'(q_b.pop_front());
      end
      nxt_a = prev_a + 2'd1;
      nxt_b = prev_b + 2'd1;
      if (busy_a && {in1_a, in2_a} != prev_a) chk("a vector order", int'({in1_a, in2_a}), int'(nxt_a));
      if (busy_b && {in1_b, in2_b} != prev_b) chk("b vector order", int'({in1_b, in2_b}), int'(nxt_b));
    end
    prev_a <= {in1_a, in2_a};
    prev_b <= {in1_b, in2_b};
  end

  task automatic kick_a(input logic [3:0] ne, input logic [3:0] fv, input logic ps);
    @(negedge clock);
    start_a = 1'b1;
    q_a.push_back('{nerr: ne, fvec: fv, ps: ps, cyc: cyc + 1 + LAT_A});
    @(negedge clock);
    start_a = 1'b0;
  endtask

  task automatic kick_b(input logic [3:0] ne, input logic [3:0] fv, input logic ps);
    @(negedge clock);
    start_b = 1'b1;
    q_b.push_back('{nerr: ne, fvec: fv, ps: ps, cyc: cyc + 1 + LAT_B});
    @(negedge clock);
    start_b = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk("drain timeout", q_a.size() + q_b.size(), 0);
    repeat (3) @(negedge clock);
  endtask

  task automatic wait_cyc(input int unsigned target);
    int n = 0;
    while (cyc != target && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk("wait cycle", int'(cyc), int'(target));
  endtask

  initial begin
    int unsigned c0;
    repeat (2) @(negedge clock);
    chk("reset busy", int'(busy_a), 0);
    chk("reset done", int'(done_a), 0);
    chk("reset pass", int'(pass_a), 0);
    chk("reset num_errors", int'(nerr_a), 0);
    chk("reset fail_vec", int'(fvec_a), 0);
    chk("reset dut_in", int'({in1_a, in2_a}), 0);
    chk("reset b busy", int'(busy_b), 0);
    reset = 1'b0;

    // Good NAND, stuck-at-1, AND
    kick_a(4'd0, 4'b0000, 1'b1); drain();
    repeat (5) @(negedge clock);
    chk("pass held in idle", int'(pass_a), 1);
    mode_a = 1; kick_a(4'd1, 4'b1000, 1'b0); drain();
    mode_a = 3; kick_a(4'd4, 4'b1111, 1'b0); drain();

    // start re-pulsed during SETTLE of vector 1 is ignored
    mode_a = 0; kick_a(4'd0, 4'b0000, 1'b1);
    repeat (4) @(negedge clock);
    chk("busy during settle", int'(busy_a), 1);
    chk("vector 1 applied", int'({in1_a, in2_a}), 1);
    start_a = 1'b1;
    @(negedge clock);
    start_a = 1'b0;
    drain();

    // start held high: done every 14 cycles
    @(negedge clock);
    start_a = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 3; i++)
      q_a.push_back('{nerr: 4'd0, fvec: 4'd0, ps: 1'b1, cyc: c0 + 1 + LAT_A + 14 * i});
    wait_cyc(c0 + 1 + LAT_A + 28);
    start_a = 1'b0;
    drain();

    // Reset mid-run (SETTLE of vector 2) after stuck-at-0 errors
    mode_a = 2;
    @(negedge clock);
    start_a = 1'b1;
    c0 = cyc;
    @(negedge clock);
    start_a = 1'b0;
    wait_cyc(c0 + 1 + 7);
    chk("midrun num_errors", int'(nerr_a), 2);
    chk("midrun fail_vec", int'(fvec_a), 3);
    chk("midrun vector 2", int'({in1_a, in2_a}), 2);
    reset = 1'b1;
    @(negedge clock);
    chk("abort busy", int'(busy_a), 0);
    chk("abort dut_in", int'({in1_a, in2_a}), 0);
    chk("abort num_errors", int'(nerr_a), 0);
    chk("abort fail_vec", int'(fvec_a), 0);
    chk("abort pass", int'(pass_a), 0);
    reset = 1'b0;
    mode_a = 0; kick_a(4'd0, 4'b0000, 1'b1); drain();

    // Zero settle cycles
    mode_b = 0; kick_b(4'd0, 4'b0000, 1'b1); drain();
    mode_b = 1; kick_b(4'd1, 4'b1000, 1'b0); drain();
    mode_b = 3; kick_b(4'd4, 4'b1111, 1'b0); drain();

`ifdef GATE_BIST_CONTINUOUS_EN
    // Continuous passes accumulate; stop sampled in the third DONE
    mode_a = 1;
    stop_a = 1'b0;
    @(negedge clock);
    start_a = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 3; i++)
      q_a.push_back('{nerr: 4'(i + 1), fvec: 4'b1000, ps: 1'b0, cyc: c0 + 1 + LAT_A + 13 * i});
    @(negedge clock);
    start_a = 1'b0;
    wait_cyc(c0 + 1 + 38);
    stop_a = 1'b1;
    drain();
    chk("continuous stopped busy", int'(busy_a), 0);
    chk("continuous num_errors", int'(nerr_a), 3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
